mem_port_arbiter: RTL

- Shares the single unified memory port between the fetch stage (read-only) and the memory-access stage (read/write).
- Serializes transactions with one outstanding at a time and routes each response back to its owner.
- Data stage has priority; a starvation counter guarantees fetch progress.
- Sits between fetcher/memaccess and the memory model, beside the hazard unit, which uses the gnt/rvalid outputs to generate stalls.

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter_if.sv | 57 +++++
 rtl/arb_starve_ctr.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | mem_port_arbiter_pkg : shared types for the memory port arbiter     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_port_arbiter_pkg;

  localparam int BIN_DIG = 32;
  localparam int BE_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic               we;
    logic [BE_W-1:0]    be;
    logic [BIN_DIG-1:0] addr;
    logic [BIN_DIG-1:0] wdata;
  } mem_payload_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// +--------------------------------------------------------------------+
// | mem_port_arbiter_if : fetch, data and memory buses of the arbiter   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic               if_req;
  logic [BIN_DIG-1:0] if_addr;
  logic               if_flush;
  logic               if_gnt;
  logic               if_rvalid;
  logic [BIN_DIG-1:0] if_rdata;

  logic               dm_req;
  logic               dm_we;
  logic [BE_W-1:0]    dm_be;
  logic [BIN_DIG-1:0] dm_addr;
  logic [BIN_DIG-1:0] dm_wdata;
  logic               dm_gnt;
  logic               dm_rvalid;
  logic [BIN_DIG-1:0] dm_rdata;

  logic               mem_req;
  logic               mem_we;
  logic [BE_W-1:0]    mem_be;
  logic [BIN_DIG-1:0] mem_addr;
  logic [BIN_DIG-1:0] mem_wdata;
  logic               mem_ready;
  logic               mem_rvalid;
  logic [BIN_DIG-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  // Requester / memory view
  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/arb_starve_ctr.sv
// +--------------------------------------------------------------------+
// | arb_starve_ctr : saturating count of data wins while fetch waits    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam int              CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +--------------------------------------------------------------------+
// | mem_port_arbiter : shares one memory port between fetch and data    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_port_arbiter_if.slave       bus_io,
  output logic                    busy_o,
  output logic                    proto_err_o
);

  arb_state_t   state_q, state_d;
  arb_owner_t   owner_q, owner_d;
  mem_payload_t pay_q,   pay_d;
  logic         mem_req_q, mem_req_d;
  logic         flush_q,   flush_d;
  logic         err_q,     err_d;

  logic         at_limit;
  logic         pick_if;
  logic         if_gnt;
  logic         dm_gnt;
  logic         own_if;
  logic         resp;
  logic         if_rvalid;
  logic         dm_rvalid;

  assign own_if = (owner_q == OWN_IF);

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (dm_gnt & bus_io.if_req),
    .clr_i      (if_gnt),
    .at_limit_o (at_limit)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    pay_d     = pay_q;
    mem_req_d = mem_req_q;
    flush_d   = flush_q;
    err_d     = err_q | (bus_io.mem_rvalid & (state_q != WAIT));
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    pick_if   = bus_io.if_req & (~bus_io.dm_req | at_limit);

    unique case (state_q)
      IDLE: begin
        // Grants are gated by reset so every output reads 0 while in reset.
        if ((bus_io.if_req | bus_io.dm_req) && rst_n) begin
          if_gnt    = pick_if;
          dm_gnt    = ~pick_if;
          mem_req_d = 1'b1;
          state_d   = ISSUE;
          if (pick_if) begin
            owner_d     = OWN_IF;
            flush_d     = bus_io.if_flush;
            pay_d.we    = 1'b0;
            pay_d.be    = '1;
            pay_d.addr  = bus_io.if_addr;
            pay_d.wdata = '0;
          end else begin
            owner_d     = OWN_DM;
            flush_d     = 1'b0;
            pay_d.we    = bus_io.dm_we;
            pay_d.be    = bus_io.dm_be;
            pay_d.addr  = bus_io.dm_addr;
            pay_d.wdata = bus_io.dm_wdata;
          end
        end
      end
      ISSUE: begin
        if (own_if && bus_io.if_flush) begin
          flush_d = 1'b1;
        end
        if (bus_io.mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (own_if && bus_io.if_flush) begin
          flush_d = 1'b1;
        end
        if (bus_io.mem_rvalid) begin
          flush_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      pay_q     <= '0;
      mem_req_q <= 1'b0;
      flush_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      pay_q     <= pay_d;
      mem_req_q <= mem_req_d;
      flush_q   <= flush_d;
      err_q     <= err_d;
    end
  end

  // A flush arriving in the same cycle as the response also discards it.
  assign resp      = bus_io.mem_rvalid & (state_q == WAIT);
  assign if_rvalid = resp & own_if & ~flush_q & ~bus_io.if_flush;
  assign dm_rvalid = resp & ~own_if;

  assign bus_io.if_gnt    = if_gnt;
  assign bus_io.dm_gnt    = dm_gnt;
  assign bus_io.if_rvalid = if_rvalid;
  assign bus_io.if_rdata  = if_rvalid ? bus_io.mem_rdata : '0;
  assign bus_io.dm_rvalid = dm_rvalid;
  assign bus_io.dm_rdata  = (dm_rvalid & ~pay_q.we) ? bus_io.mem_rdata : '0;

  assign bus_io.mem_req   = mem_req_q;
  assign bus_io.mem_we    = pay_q.we;
  assign bus_io.mem_be    = pay_q.be;
  assign bus_io.mem_addr  = pay_q.addr;
  assign bus_io.mem_wdata = pay_q.wdata;

  assign busy_o      = (state_q != IDLE);
  assign proto_err_o = err_q;

endmodule

`default_nettype wire
